// File: rtl/periph_reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// periph_reset_seq_pkg
// Shared definitions for the staggered peripheral reset sequencer:
//   - sequencer state encoding
//   - CSR register offsets relative to BASE_ADDR
//   - CTRL/STATUS bit positions
// No ports (package).
// -----------------------------------------------------------------------------
package periph_reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Register offsets from BASE_ADDR.
   localparam logic [4:0] REG_CTRL   = 5'd0;
   localparam logic [4:0] REG_DELAY  = 5'd1;
   localparam logic [4:0] REG_ENABLE = 5'd2;

   // CTRL write bits (self-clearing command strobes).
   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   // STATUS read bits.
   localparam int CTRL_BUSY     = 0;
   localparam int CTRL_DONE     = 1;
   localparam int CTRL_MASK_LSB = 4;

   // Channel index width; enough for the maximum of four channels.
   localparam int IDX_W = 2;

   // Absolute CSR address of a register; wraps within the 5-bit space.
   function automatic logic [4:0] reg_addr(input logic [4:0] base,
                                           input logic [4:0] offset);
      return base + offset;
   endfunction

endpackage

// File: rtl/periph_reset_seq_delay_counter.sv
// -----------------------------------------------------------------------------
// seq_delay_counter
// Loadable down-counter that paces the gap between channel releases.
// Load has priority over decrement; the counter parks at zero.
// Ports:
//   clk        in  clock
//   rst_n      in  synchronous active-low reset (count -> 0)
//   load       in  load load_value this cycle
//   load_value in  value to load (DELAY register)
//   dec        in  decrement enable (tick-qualified by the caller)
//   count      out current count
//   zero       out count == 0
// -----------------------------------------------------------------------------
module seq_delay_counter #(
   parameter int DELAY_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [DELAY_WIDTH-1:0] load_value,
   input  logic                   dec,
   output logic [DELAY_WIDTH-1:0] count,
   output logic                   zero
);

   assign zero = (count == '0);

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/periph_reset_seq.sv
// -----------------------------------------------------------------------------
// periph_reset_seq
// Staggered peripheral reset sequencer on the local CSR bus. After a start
// request it releases up to NUM_CHANNELS reset lines one at a time, in index
// order, waiting DELAY+1 ce ticks before each release.
// Ports:
//   clk      in  clock
//   rst_n    in  synchronous active-low reset
//   ce       in  tick enable (one-clk pulse, typically 32 kHz)
//   csr_a    in  CSR address
//   csr_di   in  CSR write data
//   csr_we   in  CSR write strobe
//   csr_do   out CSR read data, 0 when not addressed (OR-combinable)
//   start    in  start pulse
//   abort    in  abort pulse, returns every channel to reset
//   hold     in  per-channel keep-in-reset, ORed after the register
//   rst_out  out active-high channel resets
//   busy     out sequence running
//   done     out every channel processed
// -----------------------------------------------------------------------------
module periph_reset_seq
   import periph_reset_seq_pkg::*;
#(
   parameter logic [4:0]             BASE_ADDR    = 5'h1d,
   parameter int                     NUM_CHANNELS = 4,
   parameter int                     DELAY_WIDTH  = 8,
   parameter logic [DELAY_WIDTH-1:0] DFL_DELAY    = DELAY_WIDTH'(8'h20)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ce,
   input  logic [4:0]              csr_a,
   input  logic [7:0]              csr_di,
   input  logic                    csr_we,
   output logic [7:0]              csr_do,
   input  logic                    start,
   input  logic                    abort,
   input  logic [NUM_CHANNELS-1:0] hold,
   output logic [NUM_CHANNELS-1:0] rst_out,
   output logic                    busy,
   output logic                    done
);

   localparam logic [4:0]       ADDR_CTRL   = reg_addr(BASE_ADDR, REG_CTRL);
   localparam logic [4:0]       ADDR_DELAY  = reg_addr(BASE_ADDR, REG_DELAY);
   localparam logic [4:0]       ADDR_ENABLE = reg_addr(BASE_ADDR, REG_ENABLE);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHANNELS - 1);

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [NUM_CHANNELS-1:0] released, released_nxt;
   logic [NUM_CHANNELS-1:0] enable;
   logic [DELAY_WIDTH-1:0]  delay;

   logic                    cnt_load;
   logic                    cnt_dec;
   logic                    cnt_zero;
   logic [DELAY_WIDTH-1:0]  cnt_value;

   logic                    sel_ctrl, sel_delay, sel_enable;
   logic                    start_req, abort_req;

   // ---------------------------------------------------------------------
   // CSR decode and command strobes
   // ---------------------------------------------------------------------
   assign sel_ctrl   = (csr_a == ADDR_CTRL);
   assign sel_delay  = (csr_a == ADDR_DELAY);
   assign sel_enable = (csr_a == ADDR_ENABLE);

   // CTRL command bits are never stored, so they self-clear by construction.
   assign start_req = start | (csr_we & sel_ctrl & csr_di[CTRL_START]);
   assign abort_req = abort | (csr_we & sel_ctrl & csr_di[CTRL_ABORT]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         delay  <= DFL_DELAY;
         enable <= '1;
      end else if (csr_we) begin
         if (sel_delay)  delay  <= csr_di[DELAY_WIDTH-1:0];
         if (sel_enable) enable <= csr_di[NUM_CHANNELS-1:0];
      end
   end

   always_comb begin
      csr_do = '0;
      if (sel_ctrl) begin
         csr_do[CTRL_BUSY]           = busy;
         csr_do[CTRL_DONE]           = done;
         csr_do[CTRL_MASK_LSB +: 4]  = 4'(released);
      end else if (sel_delay) begin
         csr_do = 8'(delay);
      end else if (sel_enable) begin
         csr_do = 8'(enable);
      end
   end

   // ---------------------------------------------------------------------
   // Inter-release delay counter
   // ---------------------------------------------------------------------
   assign cnt_dec = ce & (state == ST_WAIT);

   seq_delay_counter #(
      .DELAY_WIDTH (DELAY_WIDTH)
   ) u_delay_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (cnt_load),
      .load_value (delay),
      .dec        (cnt_dec),
      .count      (cnt_value),
      .zero       (cnt_zero)
   );

   // ---------------------------------------------------------------------
   // Sequencer FSM: state, channel index and released mask
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         released <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         released <= released_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      released_nxt = released;
      cnt_load     = 1'b0;

      if (abort_req) begin
         // Abort beats a simultaneous start.
         state_nxt    = ST_IDLE;
         idx_nxt      = '0;
         released_nxt = '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start_req) begin
                  state_nxt    = ST_WAIT;
                  idx_nxt      = '0;
                  released_nxt = '0;
                  cnt_load     = 1'b1;
               end
            end
            ST_WAIT: begin
               // Start requests are ignored while a sequence runs.
               if (ce && cnt_zero) begin
                  // ENABLE is sampled only when the channel is reached.
                  if (enable[idx]) released_nxt[idx] = 1'b1;
                  if (idx == LAST_IDX) begin
                     state_nxt = ST_DONE;
                  end else begin
                     idx_nxt  = idx + 1'b1;
                     cnt_load = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt    = ST_IDLE;
               idx_nxt      = '0;
               released_nxt = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign busy    = (state == ST_WAIT);
   assign done    = (state == ST_DONE);
   // hold acts after the register so it never disturbs the sequence.
   assign rst_out = ~released | hold;

endmodule

// File: tb/tb_periph_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_periph_reset_seq
// Directed testbench for periph_reset_seq with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_periph_reset_seq;

   localparam logic [4:0] ADDR_CTRL   = 5'h1d;
   localparam logic [4:0] ADDR_DELAY  = 5'h1e;
   localparam logic [4:0] ADDR_ENABLE = 5'h1f;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ce;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;
   logic       start;
   logic       abort;
   logic [3:0] hold;
   logic [3:0] rst_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   periph_reset_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .csr_a   (csr_a),
      .csr_di  (csr_di),
      .csr_we  (csr_we),
      .csr_do  (csr_do),
      .start   (start),
      .abort   (abort),
      .hold    (hold),
      .rst_out (rst_out),
      .busy    (busy),
      .done    (done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      @(negedge clk);
      csr_we = 1'b0;
      csr_di = 8'h00;
      csr_a  = 5'h00;
   endtask

   task automatic csr_read_check(input string tag, input logic [4:0] a,
                                 input logic [7:0] exp);
      csr_a = a;
      #1;
      check(tag, csr_do, exp);
      csr_a = 5'h00;
   endtask

   // One ce pulse followed by three idle clocks; ro is rst_out right after
   // the edge that sampled ce.
   task automatic ce_pulse(output logic [3:0] ro);
      ce = 1'b1;
      @(negedge clk);
      ro = rst_out;
      ce = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] ro;
      logic [3:0] exp_ro;
      logic [3:0] exp_en [4];
      logic [3:0] exp_hold [4];

      exp_en   = '{4'he, 4'hc, 4'hc, 4'h4};
      exp_hold = '{4'he, 4'he, 4'ha, 4'h2};

      rst_n  = 1'b0;
      ce     = 1'b0;
      csr_a  = 5'h00;
      csr_di = 8'h00;
      csr_we = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      hold   = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("reset rst_out", rst_out, 4'hf);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      csr_read_check("reset CTRL", ADDR_CTRL, 8'h00);
      csr_read_check("reset DELAY", ADDR_DELAY, 8'h20);
      csr_read_check("reset ENABLE", ADDR_ENABLE, 8'h0f);
      csr_read_check("unaddressed read", 5'h00, 8'h00);

      // DELAY = 2: one release every 3 ce pulses
      csr_write(ADDR_DELAY, 8'h02);
      csr_read_check("DELAY readback", ADDR_DELAY, 8'h02);
      pulse_start();
      check("start busy", busy, 1'b1);
      check("start rst_out", rst_out, 4'hf);
      for (int k = 1; k <= 12; k++) begin
         ce_pulse(ro);
         exp_ro = 4'hf;
         exp_ro = exp_ro << (k / 3);
         check($sformatf("seq d2 rst_out ce%0d", k), ro, exp_ro);
         if (k == 11) check("seq d2 done before last", done, 1'b0);
         if (k == 12) begin
            check("seq d2 done", done, 1'b1);
            check("seq d2 busy", busy, 1'b0);
         end
      end
      csr_read_check("seq d2 CTRL", ADDR_CTRL, 8'hf2);

      // ENABLE = 1011, DELAY = 0: restart from DONE, channel 2 skipped
      csr_write(ADDR_ENABLE, 8'h0b);
      csr_write(ADDR_DELAY, 8'h00);
      pulse_start();
      check("restart rst_out", rst_out, 4'hf);
      check("restart done", done, 1'b0);
      for (int k = 0; k < 4; k++) begin
         ce_pulse(ro);
         check($sformatf("enable rst_out ce%0d", k + 1), ro, exp_en[k]);
      end
      check("enable done", done, 1'b1);
      csr_read_check("enable CTRL", ADDR_CTRL, 8'hb2);

      // hold = 0010 during a full sequence
      csr_write(ADDR_ENABLE, 8'h0f);
      hold = 4'b0010;
      pulse_start();
      check("hold start rst_out", rst_out, 4'hf);
      for (int k = 0; k < 4; k++) begin
         ce_pulse(ro);
         check($sformatf("hold rst_out ce%0d", k + 1), ro, exp_hold[k]);
      end
      check("hold done", done, 1'b1);
      hold = 4'b0000;
      @(negedge clk);
      check("hold released", rst_out, 4'h0);
      csr_read_check("hold CTRL", ADDR_CTRL, 8'hf2);

      // abort pin and CSR start together in DONE: abort wins
      abort  = 1'b1;
      csr_a  = ADDR_CTRL;
      csr_di = 8'h01;
      csr_we = 1'b1;
      @(negedge clk);
      abort  = 1'b0;
      csr_we = 1'b0;
      csr_di = 8'h00;
      check("abort rst_out", rst_out, 4'hf);
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      csr_read_check("abort CTRL", ADDR_CTRL, 8'h00);
      ce_pulse(ro);
      check("abort stays idle rst_out", ro, 4'hf);
      check("abort stays idle busy", busy, 1'b0);

      // CSR start bit, then CSR abort bit
      csr_write(ADDR_CTRL, 8'h01);
      check("csr start busy", busy, 1'b1);
      csr_write(ADDR_CTRL, 8'h02);
      check("csr abort busy", busy, 1'b0);
      check("csr abort rst_out", rst_out, 4'hf);

      // DELAY = 1, reach idx 2, then mid-sequence writes and reset
      csr_write(ADDR_DELAY, 8'h01);
      pulse_start();
      ce_pulse(ro);
      ce_pulse(ro);
      check("mid ch0 released", ro, 4'he);
      ce_pulse(ro);
      ce_pulse(ro);
      check("mid ch1 released", ro, 4'hc);
      csr_write(ADDR_DELAY, 8'h00);
      pulse_start();
      check("start in WAIT ignored busy", busy, 1'b1);
      check("start in WAIT ignored rst_out", rst_out, 4'hc);
      ce_pulse(ro);
      check("running count untouched", ro, 4'hc);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid reset rst_out", rst_out, 4'hf);
      check("mid reset done", done, 1'b0);
      check("mid reset busy", busy, 1'b0);
      csr_read_check("mid reset DELAY", ADDR_DELAY, 8'h20);
      csr_read_check("mid reset ENABLE", ADDR_ENABLE, 8'h0f);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
